// File: rtl/cavlc_run_before_gen.sv
// CAVLC run_before encoder: walks a 4x4 significance map top-down, issues up to two
// run_before table lookups per step and packs the pair into one right-aligned codeword.
module cavlc_run_before_gen #(
    parameter int unsigned MAX_LEN = 22
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [15:0]        coeff_nz,
    input  logic [3:0]         total_zeros,
    output logic               busy,
    output logic [5:0]         rt_addr0,
    output logic [5:0]         rt_addr1,
    input  logic [6:0]         rt_code0,
    input  logic [6:0]         rt_code1,
    output logic               rb_valid,
    input  logic               rb_ready,
    output logic [MAX_LEN-1:0] rb_bits,
    output logic [4:0]         rb_len,
    output logic               done
);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StFlush} state_t;

    typedef struct packed {
        logic [3:0]  len;
        logic [10:0] val;
    } code_t;

    // Returns {found, index} of the highest set bit.
    function automatic logic [4:0] msb16(input logic [15:0] v);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    function automatic logic [5:0] addr_of(input logic [3:0] zl, input logic [3:0] run);
        logic [2:0] zi;
        logic [2:0] rf;
        zi = (zl >= 4'd7) ? 3'd6 : 3'(zl - 4'd1);
        rf = (run >= 4'd7) ? 3'd7 : run[2:0];
        return {zi, rf};
    endfunction

    // The table ends at run 7; longer runs are a leading-zero string ending in 1.
    function automatic code_t pick(input logic [3:0] zl, input logic [3:0] run,
                                   input logic [6:0] tc);
        code_t c;
        if (zl > 4'd6 && run >= 4'd7) begin
            c.len = run - 4'd3;
            c.val = 11'd1;
        end else begin
            c.len = tc[3:0];
            c.val = {8'd0, tc[6:4]};
        end
        return c;
    endfunction

    state_t state_q, state_d;
    logic [15:0] nz_q, nz_d;
    logic [3:0]  zl_q, zl_d, pos_q, pos_d;

    logic [4:0]  top, hit1, hit2;
    logic [15:0] below_top, below_next;
    logic [3:0]  run1, run2, zl2, zl_next, pos_next;
    logic        two, last, out_free, load_beat, finish;
    code_t       c1, c2;
    logic [MAX_LEN-1:0] merged_bits;
    logic [4:0]  merged_len;

    always_comb begin
        top        = msb16(nz_q);
        below_top  = nz_q & ((16'd1 << top[3:0]) - 16'd1);
        hit1       = msb16(nz_q & ((16'd1 << pos_q) - 16'd1));
        hit2       = msb16(nz_q & ((16'd1 << hit1[3:0]) - 16'd1));
        run1       = pos_q - hit1[3:0] - 4'd1;
        zl2        = zl_q - run1;
        run2       = hit1[3:0] - hit2[3:0] - 4'd1;
        two        = hit2[4] && (zl2 != 4'd0);
        zl_next    = two ? zl2 - run2 : zl2;
        pos_next   = two ? hit2[3:0] : hit1[3:0];
        below_next = nz_q & ((16'd1 << pos_next) - 16'd1);
        last       = (below_next == 16'd0) || (zl_next == 4'd0);

        rt_addr0 = '0;
        rt_addr1 = '0;
        if (state_q == StRun && hit1[4]) begin
            rt_addr0 = addr_of(zl_q, run1);
            if (two) rt_addr1 = addr_of(zl2, run2);
        end

        c1 = pick(zl_q, run1, rt_code0);
        c2 = pick(zl2, run2, rt_code1);
        if (two) begin
            merged_bits = (MAX_LEN'(c1.val) << c2.len) | MAX_LEN'(c2.val);
            merged_len  = {1'b0, c1.len} + {1'b0, c2.len};
        end else begin
            merged_bits = MAX_LEN'(c1.val);
            merged_len  = {1'b0, c1.len};
        end
    end

    always_comb begin
        state_d   = state_q;
        nz_d      = nz_q;
        zl_d      = zl_q;
        pos_d     = pos_q;
        load_beat = 1'b0;
        finish    = 1'b0;
        out_free  = !rb_valid || rb_ready;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    nz_d    = coeff_nz;
                    zl_d    = total_zeros;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                pos_d   = top[3:0];
                state_d = (!top[4] || below_top == 16'd0 || zl_q == 4'd0) ? StFlush : StRun;
            end
            StRun: begin
                if (out_free) begin
                    load_beat = 1'b1;
                    pos_d     = pos_next;
                    zl_d      = zl_next;
                    if (last) state_d = StFlush;
                end
            end
            StFlush: begin
                if (out_free) begin
                    finish  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            nz_q     <= '0;
            zl_q     <= '0;
            pos_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rb_valid <= 1'b0;
            rb_bits  <= '0;
            rb_len   <= '0;
        end else begin
            state_q <= state_d;
            nz_q    <= nz_d;
            zl_q    <= zl_d;
            pos_q   <= pos_d;
            done    <= finish;
            if (state_q == StIdle && start) busy <= 1'b1;
            else if (finish)                busy <= 1'b0;
            if (load_beat) begin
                rb_valid <= 1'b1;
                rb_bits  <= merged_bits;
                rb_len   <= merged_len;
            end else if (finish) begin
                rb_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cavlc_run_before_gen.sv
// Bench for cavlc_run_before_gen: H.264 run_before ROM model, vector table and a
// scoreboard queue of expected beats compared as the packer accepts them.
module tb_cavlc_run_before_gen;

    typedef struct packed {
        logic [5:0]  a0;
        logic [5:0]  a1;
        logic [4:0]  len;
        logic [21:0] bits;
    } beat_t;

    typedef struct {
        logic [15:0] nz;
        logic [3:0]  tz;
        int          nb;
        beat_t       b0;
        beat_t       b1;
        int          done_k;
        int          first_k;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] coeff_nz = '0;
    logic [3:0]  total_zeros = '0;
    logic        busy, rb_valid, done;
    logic        rb_ready = 1'b1;
    logic [5:0]  rt_addr0, rt_addr1;
    logic [6:0]  rt_code0, rt_code1;
    logic [21:0] rb_bits;
    logic [4:0]  rb_len;

    int n_chk = 0;
    int n_pass = 0;
    beat_t exp_q[$];
    vec_t  vecs[7];

    cavlc_run_before_gen #(.MAX_LEN(22)) dut (
        .clk(clk), .rst(rst), .start(start), .coeff_nz(coeff_nz),
        .total_zeros(total_zeros), .busy(busy), .rt_addr0(rt_addr0), .rt_addr1(rt_addr1),
        .rt_code0(rt_code0), .rt_code1(rt_code1), .rb_valid(rb_valid), .rb_ready(rb_ready),
        .rb_bits(rb_bits), .rb_len(rb_len), .done(done)
    );

    always #5 clk = ~clk;

    // run_before VLC table: address {zl-1, run}, return {value[2:0], length[3:0]}.
    function automatic logic [6:0] rom(input logic [5:0] a);
        logic [6:0] r;
        r = '0;
        case (a)
            6'o00: r = {3'd1, 4'd1};  6'o01: r = {3'd0, 4'd1};
            6'o10: r = {3'd1, 4'd1};  6'o11: r = {3'd1, 4'd2};  6'o12: r = {3'd0, 4'd2};
            6'o20: r = {3'd3, 4'd2};  6'o21: r = {3'd2, 4'd2};  6'o22: r = {3'd1, 4'd2};
            6'o23: r = {3'd0, 4'd2};
            6'o30: r = {3'd3, 4'd2};  6'o31: r = {3'd2, 4'd2};  6'o32: r = {3'd1, 4'd2};
            6'o33: r = {3'd1, 4'd3};  6'o34: r = {3'd0, 4'd3};
            6'o40: r = {3'd3, 4'd2};  6'o41: r = {3'd2, 4'd2};  6'o42: r = {3'd3, 4'd3};
            6'o43: r = {3'd2, 4'd3};  6'o44: r = {3'd1, 4'd3};  6'o45: r = {3'd0, 4'd3};
            6'o50: r = {3'd3, 4'd2};  6'o51: r = {3'd0, 4'd3};  6'o52: r = {3'd1, 4'd3};
            6'o53: r = {3'd3, 4'd3};  6'o54: r = {3'd2, 4'd3};  6'o55: r = {3'd5, 4'd3};
            6'o56: r = {3'd4, 4'd3};
            6'o60: r = {3'd7, 4'd3};  6'o61: r = {3'd6, 4'd3};  6'o62: r = {3'd5, 4'd3};
            6'o63: r = {3'd4, 4'd3};  6'o64: r = {3'd3, 4'd3};  6'o65: r = {3'd2, 4'd3};
            6'o66: r = {3'd1, 4'd3};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        rt_code0 = rom(rt_addr0);
        rt_code1 = rom(rt_addr1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic beat_t mk(input logic [5:0] a0, input logic [5:0] a1,
                                 input logic [4:0] len, input logic [21:0] bits);
        beat_t b;
        b.a0 = a0; b.a1 = a1; b.len = len; b.bits = bits;
        return b;
    endfunction

    function automatic vec_t mkv(input logic [15:0] nz, input logic [3:0] tz, input int nb,
                                 input beat_t b0, input beat_t b1, input int dk, input int fk);
        vec_t v;
        v.nz = nz; v.tz = tz; v.nb = nb; v.b0 = b0; v.b1 = b1; v.done_k = dk; v.first_k = fk;
        return v;
    endfunction

    task automatic push_vec(input vec_t v);
        if (v.nb > 0) exp_q.push_back(v.b0);
        if (v.nb > 1) exp_q.push_back(v.b1);
    endtask

    // Drives one block; k counts falling edges after the start edge.
    task automatic run_block(input logic [15:0] nz, input logic [3:0] tz, input int stall,
                             input bit dup, input int rst_beat, input int done_k,
                             input int first_k);
        int k, beats, stall_left;
        bit pv, pr, seen_done;
        logic [5:0] pa0, pa1, ba0, ba1;
        beat_t e;
        rb_ready = 1'b1; start = 1'b1; coeff_nz = nz; total_zeros = tz;
        @(negedge clk);
        start = 1'b0; k = 1; beats = 0; pv = 0; pr = 0; pa0 = '0; pa1 = '0;
        ba0 = '0; ba1 = '0; stall_left = stall; seen_done = 0;
        check("busy_after_start", busy, 1);
        while (k < 200) begin
            if (dup && k == 2) begin
                start = 1'b1; coeff_nz = 16'h8001; total_zeros = 4'd14;
            end else begin
                start = 1'b0; coeff_nz = nz; total_zeros = tz;
            end
            if (rb_valid && (!pv || pr)) begin
                beats++; ba0 = pa0; ba1 = pa1;
                if (beats == 1 && first_k > 0) check("first_latency", k, first_k);
                if (beats == rst_beat) begin
                    rst = 1'b1; #1;
                    check("rst_valid", rb_valid, 0);
                    check("rst_busy", busy, 0);
                    @(negedge clk); rst = 1'b0;
                    repeat (4) begin
                        @(negedge clk);
                        check("rst_no_done", {done, rb_valid}, 0);
                    end
                    exp_q.delete();
                    return;
                end
            end
            rb_ready = !(rb_valid && stall_left > 0);
            if (rb_valid && stall_left > 0) stall_left--;
            if (rb_valid) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", {rb_len, rb_bits}, 0);
                end else begin
                    e = exp_q[0];
                    check("codeword", {rb_len, rb_bits}, {e.len, e.bits});
                    if (rb_ready) begin
                        check("table_addr", {ba0, ba1}, {e.a0, e.a1});
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (done) begin
                seen_done = 1;
                if (done_k > 0) check("done_latency", k, done_k);
                check("busy_at_done", {busy, rb_valid}, 0);
                break;
            end
            pv = rb_valid; pr = rb_ready; pa0 = rt_addr0; pa1 = rt_addr1;
            @(negedge clk); k++;
        end
        start = 1'b0;
        check("done_seen", seen_done, 1);
        check("beats_left", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check("done_pulse", {done, rb_valid, busy}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = mkv(16'h0166, 4'd4, 2, mk(6'o31, 6'o20, 5'd4, 22'hB),
                      mk(6'o22, 6'o00, 5'd3, 22'h3), 0, 3);
        vecs[1] = mkv(16'h8001, 4'd14, 1, mk(6'o67, 6'o00, 5'd11, 22'h1), '0, 4, 3);
        vecs[2] = mkv(16'h0101, 4'd7, 1, mk(6'o67, 6'o00, 5'd4, 22'h1), '0, 4, 3);
        vecs[3] = mkv(16'h000F, 4'd0, 0, '0, '0, 3, 0);
        vecs[4] = mkv(16'h8000, 4'd15, 0, '0, '0, 3, 0);
        vecs[5] = mkv(16'h0013, 4'd2, 1, mk(6'o12, 6'o00, 5'd2, 22'h0), '0, 4, 3);
        vecs[6] = mkv(16'hC001, 4'd13, 1, mk(6'o60, 6'o67, 5'd13, 22'h1C01), '0, 4, 3);

        #1;
        check("reset_outs", {busy, rb_valid, done, rb_len, rb_bits}, 0);
        check("reset_addr", {rt_addr0, rt_addr1}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            push_vec(vecs[i]);
            run_block(vecs[i].nz, vecs[i].tz, 0, 0, 0, vecs[i].done_k, vecs[i].first_k);
            @(negedge clk);
        end

        // Backpressure on the first beat plus a start pulse while busy.
        push_vec(vecs[0]);
        run_block(vecs[0].nz, vecs[0].tz, 5, 1, 0, 0, 3);
        @(negedge clk);

        // Reset during the second beat, then the same block from scratch.
        push_vec(vecs[0]);
        run_block(vecs[0].nz, vecs[0].tz, 0, 0, 2, 0, 3);
        push_vec(vecs[0]);
        run_block(vecs[0].nz, vecs[0].tz, 0, 0, 0, 5, 3);
        @(negedge clk);

        // Densest map: seven beats of two one-bit codes each.
        for (int i = 0; i < 7; i++) exp_q.push_back(mk(6'o00, 6'o00, 5'd2, 22'h3));
        run_block(16'hFFFE, 4'd1, 0, 0, 0, 10, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cavlc_run_before_gen.md
Name: cavlc_run_before_gen

Overview:
- Sequential run_before encoder for one 4x4/AC block in the CAVLC path. It sits upstream of the run_before VLC lookup table.
- Walks the block's significance map from the highest-frequency nonzero coefficient downward, tracking zeros_left. Per cycle it issues up to two table addresses, takes the two returned codes, and merges them into one right-aligned codeword for the bitstream packer.
- Handles run_before >= 7 with zeros_left > 6 arithmetically, because the table stops at run 7.

Parameters:
- MAX_LEN, 22, width of the merged codeword bus (two 11-bit codes max).

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- start  in  1  one-cycle pulse; loads block; ignored unless idle
- coeff_nz  in  16  zigzag significance map, bit i set = coefficient i nonzero
- total_zeros  in  4  zeros below last nonzero; must match coeff_nz
- busy  out  1  high from load until done
- rt_addr0  out  6  table address, first code: {zl_idx[2:0], run[2:0]}
- rt_addr1  out  6  table address, second code
- rt_code0  in  7  table return for addr0: [6:4] code value, [3:0] length
- rt_code1  in  7  table return for addr1
- rb_valid  out  1  merged codeword valid
- rb_ready  in  1  packer accepts
- rb_bits  out  22  merged code, right-aligned, first code in upper bits
- rb_len  out  5  total bit length, 1..22
- done  out  1  one-cycle pulse, block finished

Behaviour:
- Reset values: busy=0, rb_valid=0, rb_bits=0, rb_len=0, done=0, rt_addr0/1=0. FSM goes to IDLE; all internal state clears, including mid-block.
- FSM states: IDLE, LOAD, RUN, FLUSH.
- IDLE: on start, register coeff_nz and total_zeros into nz_r and zl_r, set busy=1, and go to LOAD.
- LOAD: pos_r = index of the highest set bit of nz_r.
  - If nz_r has fewer than 2 bits set, or zl_r==0, go to FLUSH with no beats.
  - Otherwise go to RUN.
- RUN, per step:
  - Priority encoders find n1 (highest set bit below pos_r) and n2 (highest set bit below n1).
  - run1 = pos_r - n1 - 1; zl2 = zl_r - run1.
  - Code1 always exists in RUN.
  - Code2 exists only if n2 exists and zl2 > 0; run2 = n1 - n2 - 1.
  - zl_idx = min(zl,7) - 1; run field = min(run,7).
  - rt_addr outputs are combinational from state; they are 0 when their code is absent.
- Long code: if zl > 6 and run >= 7, bypass the table and use code value 1 with length run - 3 (run 7 → 0001 len 4, run 14 → 00000000001 len 11).
- Merge: bits = (c1 << len2) | c2 and len = len1 + len2, or code1 alone.
- Output register:
  - Loads when (!rb_valid || rb_ready) in RUN.
  - On load, advance: pos_r = n2 (or n1 if single code), zl_r = remaining zeros_left.
  - Go to FLUSH after loading if the next position has no lower nonzero, or the remaining zl == 0.
  - rb_bits, rb_len and rb_valid hold stable while rb_valid && !rb_ready.
- FLUSH: wait until the output register is empty or accepted. Then pulse done for 1 cycle, drop busy and rb_valid, and return to IDLE.
- The lowest-frequency nonzero coefficient never gets a code.
- Latency: start → first rb_valid on cycle 3 (start cycle = 1). One beat per cycle under continuous rb_ready. Max beats per block = 7.
- A start received while busy is ignored. Reset asserted mid-block abandons the block: no done, no further beats.

Test Plan:
- coeff_nz=16'h0166 (pos 1,2,5,6,8), total_zeros=4, rb_ready=1 → beat1 bits=4'b1011 len=4 (rt_addr0=6'o31, rt_addr1=6'o20); beat2 bits=3'b011 len=3 (6'o22, 6'o00); then done.
- coeff_nz=16'h8001, total_zeros=14 → single beat bits=1 len=11 (arithmetic path); done.
- coeff_nz=16'h0101, total_zeros=7 → single beat rt_addr0=6'o67, bits=4'b0001 len=4; done.
- coeff_nz=16'h000F, total_zeros=0 → no rb_valid; done pulses 3 cycles after start.
- Test 1 with rb_ready low for 5 cycles on beat1 → rb_bits/rb_len stable, no beat lost or duplicated; a second start during busy is ignored.
- Reset asserted during beat2 of test 1 → rb_valid=0, busy=0 and no done. A fresh start then produces test 1's beats exactly.
